scan_test_controller: RTL and testbench

//  Sequences one scan test of the 8-flop scan chain wrapped around the 4x4 multiplier.
//  Per test: shift in a pattern, pulse one capture cycle, shift out the response, compare to expected.

---
 rtl/scan_ctrl_pkg.sv | 22 ++
 rtl/scan_piso_sipo.sv | 36 +++
 rtl/scan_test_controller.sv | 147 ++++++++++++++
 tb/tb_scan_test_controller.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/scan_ctrl_pkg.sv
// Shared types and default sizing for the scan test controller.
package scan_ctrl_pkg;

    localparam int unsigned CHAIN_LEN_DEF = 8;
    localparam int unsigned CNT_W_DEF     = 4;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StShiftIn  = 3'd1,
        StCapture  = 3'd2,
        StShiftOut = 3'd3,
        StDone     = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        ModeHold     = 2'd0,
        ModeLoad     = 2'd1,
        ModeShiftOut = 2'd2,
        ModeShiftIn  = 2'd3
    } sr_mode_e;

endpackage

// File: rtl/scan_piso_sipo.sv
// Shift register with parallel load, shift-left-out (msb is the serial output)
// and shift-left-in (serial input enters at the lsb).
module scan_piso_sipo
    import scan_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = CHAIN_LEN_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  sr_mode_e         mode,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q;
        unique case (mode)
            ModeLoad:     q_d = load_val;
            ModeShiftOut: q_d = {q[WIDTH-2:0], 1'b0};
            ModeShiftIn:  q_d = {q[WIDTH-2:0], ser_in};
            default:      q_d = q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= q_d;
        end
    end

endmodule

// File: rtl/scan_test_controller.sv
// Runs one scan test: shift a pattern into the chain, capture once, shift the
// response out and compare it with the golden value.
module scan_test_controller
    import scan_ctrl_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = CHAIN_LEN_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CHAIN_LEN-1:0] pattern,
    input  logic [CHAIN_LEN-1:0] expected,
    input  logic                 scan_out,
    output logic                 scan_en,
    output logic                 scan_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CHAIN_LEN-1:0] captured
);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CHAIN_LEN-1:0] expected_q;
    logic [CHAIN_LEN-1:0] pat_q, rsp_q, rsp_next;
    logic [CHAIN_LEN-1:0] captured_q;
    logic                 pass_q;
    sr_mode_e             pat_mode, rsp_mode;
    logic                 accept, finish, last;

    scan_piso_sipo #(
        .WIDTH(CHAIN_LEN)
    ) u_pattern_sr (
        .clk      (clk),
        .rst      (rst),
        .mode     (pat_mode),
        .load_val (pattern),
        .ser_in   (1'b0),
        .q        (pat_q)
    );

    scan_piso_sipo #(
        .WIDTH(CHAIN_LEN)
    ) u_response_sr (
        .clk      (clk),
        .rst      (rst),
        .mode     (rsp_mode),
        .load_val ('0),
        .ser_in   (scan_out),
        .q        (rsp_q)
    );

    // Value the response register takes on the final shift-out edge.
    assign rsp_next = {rsp_q[CHAIN_LEN-2:0], scan_out};
    assign last     = (cnt_q == CNT_W'(CHAIN_LEN - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pat_mode = ModeHold;
        rsp_mode = ModeHold;
        accept   = 1'b0;
        finish   = 1'b0;
        scan_en  = 1'b0;
        scan_in  = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        unique case (state_q)
            StIdle: begin
                busy = 1'b0;
                if (start && !abort) begin
                    accept   = 1'b1;
                    pat_mode = ModeLoad;
                    cnt_d    = '0;
                    state_d  = StShiftIn;
                end
            end
            StShiftIn: begin
                scan_en  = 1'b1;
                scan_in  = pat_q[CHAIN_LEN-1];
                pat_mode = ModeShiftOut;
                if (last) begin
                    cnt_d   = '0;
                    state_d = StCapture;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StCapture: begin
                state_d = StShiftOut;
            end
            StShiftOut: begin
                scan_en  = 1'b1;
                rsp_mode = ModeShiftIn;
                if (last) begin
                    cnt_d   = '0;
                    finish  = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort freezes everything and drops back to idle without a result.
        if (abort && (state_q != StIdle)) begin
            state_d  = StIdle;
            cnt_d    = '0;
            pat_mode = ModeHold;
            rsp_mode = ModeHold;
            finish   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            expected_q <= '0;
            captured_q <= '0;
            pass_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                expected_q <= expected;
            end
            if (finish) begin
                captured_q <= rsp_next;
                pass_q     <= (rsp_next == expected_q);
            end
        end
    end

    assign captured = captured_q;
    assign pass     = pass_q;

endmodule

// File: tb/tb_scan_test_controller.sv
// Directed bench for scan_test_controller with a behavioural 8-flop chain whose
// capture loads flops[7:4] * flops[3:0].
module tb_scan_test_controller;

    logic       clk = 1'b0;
    logic       rst, start, abort, scan_out;
    logic [7:0] pattern, expected;
    logic       scan_en, scan_in, busy, done, pass;
    logic [7:0] captured;
    logic [7:0] chain;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    scan_test_controller dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .pattern  (pattern),
        .expected (expected),
        .scan_out (scan_out),
        .scan_en  (scan_en),
        .scan_in  (scan_in),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .captured (captured)
    );

    assign scan_out = chain[7];

    always @(posedge clk) begin
        if (scan_en) chain <= {chain[6:0], scan_in};
        else         chain <= 8'(chain[7:4]) * 8'(chain[3:0]);
    end

    // Starts a test at the current negedge (edge 0 follows) and observes cycles 1..last_cyc.
    task automatic run_test(input logic [7:0] pat, input logic [7:0] exp,
                            input int abort_cyc, input int restart_cyc, input int rst_cyc,
                            input int snap_cyc, input int last_cyc,
                            output logic [7:0] sin_seq, output int en_low,
                            output int done_cyc, output int done_cnt, output logic [12:0] snap);
        sin_seq  = '0;
        en_low   = 0;
        done_cyc = 0;
        done_cnt = 0;
        snap     = '1;
        pattern  = pat;
        expected = exp;
        start    = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= last_cyc; c++) begin
            if (c <= 8) sin_seq = {sin_seq[6:0], scan_in};
            if (c <= 17 && !scan_en) en_low++;
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = c;
            end
            if (c == snap_cyc) snap = {scan_en, scan_in, busy, done, pass, captured};
            start = (c == restart_cyc);
            abort = (c == abort_cyc);
            rst   = (c == rst_cyc);
            if (c == restart_cyc) begin
                pattern  = ~pat;
                expected = ~exp;
            end
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; pattern = '0; expected = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_tests++; if (scan_en !== 1'b0) begin n_fail++; $display("FAIL reset scan_en got %b want 0", scan_en); end
        n_tests++; if (scan_in !== 1'b0) begin n_fail++; $display("FAIL reset scan_in got %b want 0", scan_in); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy got %b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset done got %b want 0", done); end
        n_tests++; if (pass !== 1'b0) begin n_fail++; $display("FAIL reset pass got %b want 0", pass); end
        n_tests++; if (captured !== 8'h00) begin n_fail++; $display("FAIL reset captured got %h want 00", captured); end
    endtask

    task automatic test_basic();
        logic [7:0] s; int el, dc, dn; logic [12:0] sn;
        run_test(8'hFF, 8'hE1, 0, 0, 0, 1, 24, s, el, dc, dn, sn);
        n_tests++; if (s !== 8'hFF) begin n_fail++; $display("FAIL basic scan_in_seq got %h want ff", s); end
        n_tests++; if (el !== 1) begin n_fail++; $display("FAIL basic scan_en_low got %0d want 1", el); end
        n_tests++; if (dc !== 18) begin n_fail++; $display("FAIL basic done_cycle got %0d want 18", dc); end
        n_tests++; if (dn !== 1) begin n_fail++; $display("FAIL basic done_count got %0d want 1", dn); end
        n_tests++; if (captured !== 8'hE1) begin n_fail++; $display("FAIL basic captured got %h want e1", captured); end
        n_tests++; if (pass !== 1'b1) begin n_fail++; $display("FAIL basic pass got %b want 1", pass); end
        n_tests++; if (sn !== {5'b11100, 8'h00}) begin n_fail++; $display("FAIL basic cycle1_outputs got %h want %h", sn, {5'b11100, 8'h00}); end
    endtask

    task automatic test_mismatch();
        logic [7:0] s; int el, dc, dn; logic [12:0] sn;
        run_test(8'h32, 8'h07, 0, 0, 0, 0, 24, s, el, dc, dn, sn);
        n_tests++; if (s !== 8'h32) begin n_fail++; $display("FAIL mismatch scan_in_seq got %h want 32", s); end
        n_tests++; if (captured !== 8'h06) begin n_fail++; $display("FAIL mismatch captured got %h want 06", captured); end
        n_tests++; if (pass !== 1'b0) begin n_fail++; $display("FAIL mismatch pass got %b want 0", pass); end
        n_tests++; if (dn !== 1) begin n_fail++; $display("FAIL mismatch done_count got %0d want 1", dn); end
    endtask

    task automatic test_start_while_busy();
        logic [7:0] s; int el, dc, dn; logic [12:0] sn;
        run_test(8'h57, 8'h23, 0, 5, 0, 0, 24, s, el, dc, dn, sn);
        n_tests++; if (captured !== 8'h23) begin n_fail++; $display("FAIL busy_start captured got %h want 23", captured); end
        n_tests++; if (pass !== 1'b1) begin n_fail++; $display("FAIL busy_start pass got %b want 1", pass); end
        n_tests++; if (dn !== 1) begin n_fail++; $display("FAIL busy_start done_count got %0d want 1", dn); end
        n_tests++; if (dc !== 18) begin n_fail++; $display("FAIL busy_start done_cycle got %0d want 18", dc); end
    endtask

    task automatic test_abort();
        logic [7:0] s; int el, dc, dn; logic [12:0] sn;
        run_test(8'hA3, 8'h1E, 12, 0, 0, 13, 24, s, el, dc, dn, sn);
        n_tests++; if (dn !== 0) begin n_fail++; $display("FAIL abort done_count got %0d want 0", dn); end
        n_tests++; if (sn !== {5'b00001, 8'h23}) begin n_fail++; $display("FAIL abort after_outputs got %h want %h", sn, {5'b00001, 8'h23}); end
        n_tests++; if (captured !== 8'h23) begin n_fail++; $display("FAIL abort captured_kept got %h want 23", captured); end
        run_test(8'h44, 8'h10, 0, 0, 0, 0, 24, s, el, dc, dn, sn);
        n_tests++; if (captured !== 8'h10) begin n_fail++; $display("FAIL abort_rerun captured got %h want 10", captured); end
        n_tests++; if (pass !== 1'b1) begin n_fail++; $display("FAIL abort_rerun pass got %b want 1", pass); end
        n_tests++; if (dc !== 18) begin n_fail++; $display("FAIL abort_rerun done_cycle got %0d want 18", dc); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] s; int el, dc, dn; logic [12:0] sn;
        run_test(8'h99, 8'h51, 0, 0, 9, 10, 24, s, el, dc, dn, sn);
        n_tests++; if (sn !== 13'h0) begin n_fail++; $display("FAIL rst_mid outputs got %h want 0000", sn); end
        n_tests++; if (dn !== 0) begin n_fail++; $display("FAIL rst_mid done_count got %0d want 0", dn); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] s; int el, dc, dn; logic [12:0] sn;
        run_test(8'hFF, 8'hE1, 0, 0, 0, 0, 18, s, el, dc, dn, sn);
        n_tests++; if (dc !== 18) begin n_fail++; $display("FAIL b2b_first done_cycle got %0d want 18", dc); end
        n_tests++; if (captured !== 8'hE1) begin n_fail++; $display("FAIL b2b_first captured got %h want e1", captured); end
        n_tests++; if (pass !== 1'b1) begin n_fail++; $display("FAIL b2b_first pass got %b want 1", pass); end
        run_test(8'h32, 8'h06, 0, 0, 0, 0, 24, s, el, dc, dn, sn);
        n_tests++; if (dc !== 18) begin n_fail++; $display("FAIL b2b_second done_cycle got %0d want 18", dc); end
        n_tests++; if (captured !== 8'h06) begin n_fail++; $display("FAIL b2b_second captured got %h want 06", captured); end
        n_tests++; if (pass !== 1'b1) begin n_fail++; $display("FAIL b2b_second pass got %b want 1", pass); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_mismatch();
        test_start_while_busy();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
